// File: rtl/icache_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_loader_if
// Description : Control, byte-stream and RAM write-port bundle for the
//               instruction-RAM boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // load control
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic                  abort;

    // byte stream
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;

    // instruction RAM write port
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;

    // status
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [15:0]           checksum;

    // the side that requests loads and supplies bytes
    modport master (
        output start, base_addr, word_cnt, abort, s_data, s_valid,
        input  s_ready, wr_data, wr_addr, wr_en,
        input  cpu_hold, busy, done, err, checksum
    );

    // the loader itself
    modport slave (
        input  start, base_addr, word_cnt, abort, s_data, s_valid,
        output s_ready, wr_data, wr_addr, wr_en,
        output cpu_hold, busy, done, err, checksum
    );
endinterface
`default_nettype wire

// File: rtl/icache_loader.sv
`default_nettype none
// ============================================================================
// Module      : icache_loader
// Description : Boot-time instruction-RAM filler. Packs a valid/ready byte
//               stream little-endian into RAM words, writes them from a
//               programmable base address, keeps the soft CPU in reset until
//               the image is complete and keeps a 16-bit byte checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_loader #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  wire logic      wr_clk,
    input  wire logic      wr_rst,
    icache_loader_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BPW    = DATA_WIDTH / 8;
    localparam int c_BIDX_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    localparam logic [c_BIDX_W-1:0]   c_LAST_LANE = c_BIDX_W'(c_BPW - 1);
    localparam logic [c_BIDX_W-1:0]   c_LANE_ONE  = c_BIDX_W'(1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
    // largest legal word count: the whole RAM
    localparam logic [ADDR_WIDTH:0]   c_MAX_CNT   = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [c_BIDX_W-1:0]   r_byte_idx;
    logic [DATA_WIDTH-1:0] r_asm;

    logic                  r_s_ready;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_wr_en;
    logic                  r_cpu_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           r_checksum;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_cnt_bad;
    logic                  w_last_lane;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_word;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_accept    = bus.s_valid && r_s_ready;
    assign w_cnt_bad   = (bus.word_cnt == '0) || (bus.word_cnt > c_MAX_CNT);
    assign w_last_lane = (r_byte_idx == c_LAST_LANE);
    assign w_last_word = (r_word_idx == (r_cnt - c_CNT_ONE));
    // word index is truncated so the RAM address wraps at the top of memory
    assign w_word_addr = r_base + r_word_idx[ADDR_WIDTH-1:0];

    // Completed word: lower lanes from the assembly register, top lane is the
    // byte arriving now, so the word can be registered without a bubble.
    always_comb begin
        w_word                    = r_asm;
        w_word[DATA_WIDTH-1 -: 8] = bus.s_data;
    end

    // ------------------------------------------------------------------------
    // Load sequencer: byte packing, RAM writes, CPU hold and status
    // ------------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_s_ready  <= 1'b0;
            r_wr_data  <= '0;
            r_wr_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_cpu_hold <= HOLD_AT_RESET;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_checksum <= '0;
        end else begin
            // single-cycle strobes
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_s_ready <= 1'b0;
                    if (bus.start) begin
                        if (w_cnt_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_base     <= bus.base_addr;
                            r_cnt      <= bus.word_cnt;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_checksum <= '0;
                            r_err      <= 1'b0;
                            r_cpu_hold <= 1'b1;
                            r_busy     <= 1'b1;
                            r_s_ready  <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (bus.abort) begin
                        // a byte accepted in this cycle, and any word it
                        // would complete, is dropped
                        r_err     <= 1'b1;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_accept) begin
                        r_checksum <= r_checksum + {8'h00, bus.s_data};
                        for (int i = 0; i < c_BPW; i++) begin
                            if (r_byte_idx == c_BIDX_W'(i)) begin
                                r_asm[i*8 +: 8] <= bus.s_data;
                            end
                        end
                        if (w_last_lane) begin
                            r_byte_idx <= '0;
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= w_word;
                            r_wr_addr  <= w_word_addr;
                            r_word_idx <= r_word_idx + c_CNT_ONE;
                            if (w_last_word) begin
                                r_s_ready <= 1'b0;
                                r_state   <= S_FLUSH;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + c_LANE_ONE;
                        end
                    end
                end

                S_FLUSH: begin
                    // the final word's write strobe is on the bus this cycle
                    if (bus.abort) begin
                        r_err     <= 1'b1;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // release the CPU only after the last RAM write
                    r_cpu_hold <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.s_ready  = r_s_ready;
    assign bus.wr_data  = r_wr_data;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_en    = r_wr_en;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.checksum = r_checksum;

endmodule
`default_nettype wire
